sent_tx_scheduler: RTL
======================

SENT_TX_SCHEDULER -- requirements
Module: sent_tx_scheduler

Interface
REQ-001 Parameter DATAWIDTH, default 8, width of the FIFO read-data bus.
REQ-002 Parameter PERIODWIDTH, default 16, width of the frame-period counter.
REQ-003 PCLK  input  1  sole clock; all state changes on rising edge.
REQ-004 PRESETn  input  1  reset, asynchronous, active-low.
REQ-005 sched_en  input  1  level; 1 = schedule frames continuously.
REQ-006 frame_period  input  PERIODWIDTH  minimum PCLK cycles from one tx_start to the next.
REQ-007 fifo_empty  input  1  data FIFO has no entries.
REQ-008 fifo_rdata  input  DATAWIDTH  FIFO head data, valid the cycle after fifo_rd.
REQ-009 fifo_rd  output  1  one-cycle FIFO pop strobe.
REQ-010 tx_done  input  1  one-cycle pulse from the SENT transmitter at frame end.
REQ-011 tx_start  output  1  one-cycle frame-start pulse to the transmitter.
REQ-012 tx_data  output  2*DATAWIDTH  frame payload, {hi byte, lo byte}; stable from tx_start until the next tx_start.
REQ-013 underrun_clr  input  1  one-cycle clear of underrun.
REQ-014 underrun  output  1  sticky; a frame was sent with repeated data.
REQ-015 frame_cnt  output  8  frames started, wraps 255->0.
REQ-016 busy  output  1  1 in every state except IDLE.

Function
REQ-017 FSM states: IDLE, FETCH_HI, LATCH_HI, FETCH_LO, LATCH_LO, START, WAIT_DONE, GAP.
REQ-018 IDLE -> FETCH_HI when sched_en=1; else remain in IDLE.
REQ-019 FETCH_HI, fifo_empty=0: assert fifo_rd for 1 cycle -> LATCH_HI; LATCH_HI captures fifo_rdata into the hi staging byte -> FETCH_LO.
REQ-020 FETCH_LO and LATCH_LO: same pop-and-capture sequence for the lo staging byte -> START.
REQ-021 FETCH_HI with fifo_empty=1: no pop, staging keeps the previous frame's bytes, set underrun -> START; FETCH_LO with fifo_empty=1: same, hi byte is kept.
REQ-022 START: copy staging to tx_data, pulse tx_start for 1 cycle, increment frame_cnt, load the gap counter with frame_period-1 (0 if frame_period=0) -> WAIT_DONE.
REQ-023 The gap counter decrements by 1 every cycle from WAIT_DONE onward and saturates at 0.
REQ-024 WAIT_DONE: remain until tx_done=1 -> GAP; a tx_done in any other state is ignored.
REQ-025 GAP: when the counter = 0: -> FETCH_HI if sched_en=1, else -> IDLE.
REQ-026 Happy-path latency: tx_start asserts 5 cycles after sched_en is sampled 1 in IDLE.
REQ-027 sched_en deassertion mid-frame does not abort the frame; it takes effect only at the GAP exit.
REQ-028 Spacing between tx_start pulses = max(frame_period, cycles to tx_done + 5); frame_period 0 or 1 gives back-to-back frames.
REQ-029 underrun_clr and a new underrun event in the same cycle: set wins.
REQ-030 fifo_rd never asserts while fifo_empty=1; at most 2 pops per frame.

Reset
REQ-031 PRESETn=0 immediately forces IDLE, regardless of clock and state.
REQ-032 Reset values: fifo_rd=0, tx_start=0, tx_data=0, staging=0, underrun=0, frame_cnt=0, busy=0, gap counter=0.
REQ-033 Reset asserted mid-frame discards staged data; the first frame after release re-fetches from the FIFO.

Verification
REQ-034 FIFO holds 0x12,0x34; frame_period=100; sched_en pulsed -> 2 fifo_rd pulses, tx_start 5 cycles later, tx_data=16'h1234, frame_cnt=1.
REQ-035 Continuous sched_en=1, frame_period=100, tx_done 40 cycles after each tx_start -> tx_start exactly every 100 cycles.
REQ-036 Same setup, tx_done 150 cycles after tx_start -> tx_start spacing 155 cycles.
REQ-037 FIFO empty after the first frame (0xAB,0xCD) -> second frame tx_data=16'hABCD, underrun=1, no fifo_rd; underrun_clr -> underrun=0.
REQ-038 PRESETn pulsed low during WAIT_DONE -> all outputs at reset values asynchronously; a late tx_done is ignored.
REQ-039 Run 256 frames -> frame_cnt wraps to 0; sched_en dropped in WAIT_DONE -> the frame completes, then IDLE with busy=0.

Source files
------------

// File: rtl/sent_tx_scheduler_if.sv
// rtl/sent_tx_scheduler_if.sv - scheduler-side bundle: FIFO, transmitter and status signals
interface sent_tx_scheduler_if #(
    parameter int DATAWIDTH   = 8,
    parameter int PERIODWIDTH = 16
);
    logic                   sched_en;
    logic [PERIODWIDTH-1:0] frame_period;
    logic                   fifo_empty;
    logic [DATAWIDTH-1:0]   fifo_rdata;
    logic                   fifo_rd;
    logic                   tx_done;
    logic                   tx_start;
    logic [2*DATAWIDTH-1:0] tx_data;
    logic                   underrun_clr;
    logic                   underrun;
    logic [7:0]             frame_cnt;
    logic                   busy;

    modport master (
        input  sched_en, frame_period, fifo_empty, fifo_rdata, tx_done, underrun_clr,
        output fifo_rd, tx_start, tx_data, underrun, frame_cnt, busy
    );

    modport slave (
        output sched_en, frame_period, fifo_empty, fifo_rdata, tx_done, underrun_clr,
        input  fifo_rd, tx_start, tx_data, underrun, frame_cnt, busy
    );
endinterface

// File: rtl/sent_tx_scheduler.sv
// rtl/sent_tx_scheduler.sv - fetches two FIFO bytes per frame and paces SENT frame starts
module sent_tx_scheduler #(
    parameter int DATAWIDTH   = 8,
    parameter int PERIODWIDTH = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    sent_tx_scheduler_if.master   bus
);
    typedef enum logic [2:0] {
        IDLE, FETCH_HI, LATCH_HI, FETCH_LO, LATCH_LO, START, WAIT_DONE, GAP
    } state_t;

    // The fetch/latch sequence takes this many cycles from GAP exit to the
    // next START, so the gap may end that early and still honour frame_period
    // measured tx_start to tx_start.
    localparam logic [PERIODWIDTH-1:0] LEAD = PERIODWIDTH'(5);

    state_t                 state_q, state_d;
    logic [DATAWIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*DATAWIDTH-1:0] tx_data_q, tx_data_d;
    logic                   underrun_q, underrun_d, underrun_set;
    logic [7:0]             frame_cnt_q, frame_cnt_d;
    logic [PERIODWIDTH-1:0] gap_q, gap_d;
    logic                   fifo_rd_c;
    logic                   gap_ok;
    state_t                 exit_state;

    assign gap_ok     = (gap_q <= LEAD);
    assign exit_state = bus.sched_en ? FETCH_HI : IDLE;

    // State register; reset drops straight back to IDLE.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state, FIFO pop strobe, staging capture and underrun detection.
    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        fifo_rd_c    = 1'b0;
        underrun_set = 1'b0;
        case (state_q)
            IDLE:     if (bus.sched_en) state_d = FETCH_HI;
            FETCH_HI: begin
                if (!bus.fifo_empty) begin
                    fifo_rd_c = 1'b1;
                    state_d   = LATCH_HI;
                end else begin
                    underrun_set = 1'b1;
                    state_d      = START;
                end
            end
            LATCH_HI: begin
                hi_d    = bus.fifo_rdata;
                state_d = FETCH_LO;
            end
            FETCH_LO: begin
                if (!bus.fifo_empty) begin
                    fifo_rd_c = 1'b1;
                    state_d   = LATCH_LO;
                end else begin
                    underrun_set = 1'b1;
                    state_d      = START;
                end
            end
            LATCH_LO: begin
                lo_d    = bus.fifo_rdata;
                state_d = START;
            end
            START:     state_d = WAIT_DONE;
            // A done with the gap already spent skips GAP so no cycle is lost.
            WAIT_DONE: if (bus.tx_done) state_d = gap_ok ? exit_state : GAP;
            GAP:       if (gap_ok) state_d = exit_state;
            default:   state_d = IDLE;
        endcase
    end

    // Frame payload, frame counter, gap counter and sticky underrun updates.
    always_comb begin
        tx_data_d   = tx_data_q;
        frame_cnt_d = frame_cnt_q;
        gap_d       = gap_q;
        underrun_d  = underrun_set | (underrun_q & ~bus.underrun_clr);
        if (state_d == START) begin
            tx_data_d   = {hi_d, lo_d};
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
        if (state_q == START) begin
            gap_d = (bus.frame_period == '0) ? '0 : bus.frame_period - PERIODWIDTH'(1);
        end else if (gap_q != '0) begin
            gap_d = gap_q - PERIODWIDTH'(1);
        end
    end

    // Datapath registers; reset discards staged bytes and all counters.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            hi_q        <= '0;
            lo_q        <= '0;
            tx_data_q   <= '0;
            underrun_q  <= 1'b0;
            frame_cnt_q <= 8'd0;
            gap_q       <= '0;
        end else begin
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            tx_data_q   <= tx_data_d;
            underrun_q  <= underrun_d;
            frame_cnt_q <= frame_cnt_d;
            gap_q       <= gap_d;
        end
    end

    assign bus.fifo_rd   = fifo_rd_c;
    assign bus.tx_start  = (state_q == START);
    assign bus.tx_data   = tx_data_q;
    assign bus.underrun  = underrun_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
